// File: rtl/exp_master_pkg.sv
// Shared register map, command constants and master FSM state type for the
// exponent accelerator and its Avalon-MM master.
package exp_master_pkg;

  localparam logic [3:0] REG_X      = 4'd0;
  localparam logic [3:0] REG_A      = 4'd1;
  localparam logic [3:0] REG_CTRL   = 4'd2;
  localparam logic [3:0] REG_STATUS = 4'd3;
  localparam logic [3:0] REG_RESULT = 4'd4;

  localparam logic [31:0] CTRL_START      = 32'h1;
  localparam int unsigned STATUS_DONE_BIT = 0;

  typedef enum logic [3:0] {
    StIdle,
    StWrX,
    StWrA,
    StWrGo,
    StRdStat,
    StWaitStat,
    StRdRes,
    StWaitRes,
    StResp
  } state_e;

endpackage

// File: rtl/exp_master_if.sv
// Avalon-MM register bus between the exponent master and the accelerator slave.
interface exp_master_if;

  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/avmm_txn.sv
// Single Avalon-MM transfer engine: presents one read or write while i_req is high,
// holds it through waitrequest, and for reads waits READ_LATENCY cycles for data.
module avmm_txn #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_accept,
  output logic        o_done,
  output logic [31:0] o_rdata,
  exp_master_if.master m
);

  localparam int unsigned LatW = $clog2(READ_LATENCY + 1);

  logic            r_wait;
  logic [LatW-1:0] r_cnt;
  logic            w_strobe;
  logic            w_last;

  // The strobe is a pure function of the request, so it holds itself during stalls.
  assign w_strobe    = i_req && !r_wait;
  assign m.read      = w_strobe && !i_we;
  assign m.write     = w_strobe && i_we;
  assign m.address   = w_strobe ? i_addr : 4'd0;
  assign m.writedata = (w_strobe && i_we) ? i_wdata : 32'd0;

  assign o_accept = w_strobe && !m.waitrequest;
  assign w_last   = r_wait && (r_cnt == LatW'(READ_LATENCY));
  assign o_done   = (o_accept && i_we) || w_last;
  assign o_rdata  = m.readdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= 1'b0;
      r_cnt  <= '0;
    end else if (o_accept && !i_we) begin
      r_wait <= 1'b1;
      r_cnt  <= LatW'(1);
    end else if (w_last) begin
      r_wait <= 1'b0;
    end else if (r_wait) begin
      r_cnt <= r_cnt + LatW'(1);
    end
  end

endmodule

// File: rtl/exp_master.sv
// Avalon-MM master that runs one x^a job on the accelerator per accepted command:
// write X, A, start; poll STATUS; read RESULT; return it on the response port.
module exp_master
  import exp_master_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_POLLS    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_x,
  input  logic [31:0] cmd_a,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  exp_master_if.master m
);

  localparam int unsigned PollW = $clog2(MAX_POLLS + 1);

  state_e           r_state, w_state_d;
  logic [31:0]      r_x, r_a, r_result;
  logic [PollW-1:0] r_polls;
  logic             r_timeout, r_rsp_valid;

  logic             w_req, w_we, w_txn_accept, w_txn_done;
  logic [3:0]       w_addr;
  logic [31:0]      w_wdata, w_rdata;
  logic             w_done_bit, w_poll_max;

  assign w_done_bit = w_rdata[STATUS_DONE_BIT];
  assign w_poll_max = (r_polls == PollW'(MAX_POLLS));

  avmm_txn #(
    .READ_LATENCY(READ_LATENCY)
  ) u_txn (
    .clk     (clk),
    .reset   (reset),
    .i_req   (w_req),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_accept(w_txn_accept),
    .o_done  (w_txn_done),
    .o_rdata (w_rdata),
    .m       (m)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_req     = 1'b0;
    w_we      = 1'b0;
    w_addr    = REG_X;
    w_wdata   = 32'd0;
    unique case (r_state)
      StIdle: if (cmd_valid) w_state_d = StWrX;
      StWrX: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = REG_X;
        w_wdata = r_x;
        if (w_txn_done) w_state_d = StWrA;
      end
      StWrA: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = REG_A;
        w_wdata = r_a;
        if (w_txn_done) w_state_d = StWrGo;
      end
      StWrGo: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = REG_CTRL;
        w_wdata = CTRL_START;
        if (w_txn_done) w_state_d = StRdStat;
      end
      StRdStat: begin
        w_req  = 1'b1;
        w_addr = REG_STATUS;
        if (w_txn_accept) w_state_d = StWaitStat;
      end
      StWaitStat: begin
        w_req  = 1'b1;
        w_addr = REG_STATUS;
        if (w_txn_done) begin
          if (w_done_bit)      w_state_d = StRdRes;
          else if (w_poll_max) w_state_d = StResp;
          else                 w_state_d = StRdStat;
        end
      end
      StRdRes: begin
        w_req  = 1'b1;
        w_addr = REG_RESULT;
        if (w_txn_accept) w_state_d = StWaitRes;
      end
      StWaitRes: begin
        w_req  = 1'b1;
        w_addr = REG_RESULT;
        if (w_txn_done) w_state_d = StResp;
      end
      StResp: if (r_rsp_valid && rsp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x         <= 32'd0;
      r_a         <= 32'd0;
      r_polls     <= '0;
      r_result    <= 32'd0;
      r_timeout   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (r_state == StIdle && cmd_valid) begin
        r_x       <= cmd_x;
        r_a       <= cmd_a;
        r_polls   <= '0;
        r_result  <= 32'd0;
        r_timeout <= 1'b0;
      end
      if (r_state == StRdStat && w_txn_accept && !w_poll_max) begin
        r_polls <= r_polls + PollW'(1);
      end
      if (r_state == StWaitStat && w_txn_done && !w_done_bit && w_poll_max) begin
        r_result  <= 32'd0;
        r_timeout <= 1'b1;
      end
      if (r_state == StWaitRes && w_txn_done) begin
        r_result  <= w_rdata;
        r_timeout <= 1'b0;
      end
      // Valid rises one cycle into RESP, after the result register has settled.
      if (r_state == StResp && !r_rsp_valid)  r_rsp_valid <= 1'b1;
      else if (r_rsp_valid && rsp_ready)      r_rsp_valid <= 1'b0;
    end
  end

  assign cmd_ready   = (r_state == StIdle);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_result;
  assign rsp_timeout = r_timeout;

endmodule

// File: tb/tb_exp_master.sv
// Randomised self-checking bench: a behavioural accelerator slave plus a
// second master instance wired to a slave that never reports done.
module tb_exp_master;
  import exp_master_pkg::*;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset;
  logic        cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_x = 32'd0, cmd_a = 32'd0;
  logic        cmd_ready, rsp_valid, rsp_timeout;
  logic [31:0] rsp_result;
  logic        t_cmd_valid = 1'b0, t_rsp_ready = 1'b0;
  logic        t_cmd_ready, t_rsp_valid, t_rsp_timeout;
  logic [31:0] t_rsp_result;

  int n_checks = 0, n_pass = 0;

  always #5 if (clk_en) clk = ~clk;

  exp_master_if bus ();
  exp_master_if bus2 ();

  exp_master #(.READ_LATENCY(1), .MAX_POLLS(1024)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_a(cmd_a), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .m(bus)
  );

  exp_master #(.READ_LATENCY(2), .MAX_POLLS(4)) dut_to (
    .clk(clk), .reset(reset), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
    .cmd_x(cmd_x), .cmd_a(cmd_a), .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready),
    .rsp_result(t_rsp_result), .rsp_timeout(t_rsp_timeout), .m(bus2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] pow32(input logic [31:0] x, input logic [31:0] a);
    logic [31:0] r = 32'd1;
    for (int unsigned i = 0; i < a; i++) r = r * x;
    return r;
  endfunction

  // ---- behavioural accelerator slave for dut ----
  logic [31:0] s_x = 0, s_a = 0;
  int          s_polls = 0, done_after = 1;
  int          stalls = 0, dir_used = 0, stall_total = 0;
  logic [3:0]  stall_addr = 4'd0;
  logic        rand_en = 1'b0, rand_bit = 1'b0;
  logic [36:0] txn_log[$];

  assign bus.waitrequest = (bus.read || bus.write) &&
                           (rand_bit || (bus.address == stall_addr && dir_used < stall_total));

  always @(posedge clk) begin
    rand_bit <= rand_en && ($urandom_range(0, 3) == 0);
    if (bus.read || bus.write) begin
      if (bus.waitrequest) begin
        stalls <= stalls + 1;
        if (bus.address == stall_addr && dir_used < stall_total) dir_used <= dir_used + 1;
      end else begin
        txn_log.push_back({bus.write, bus.address, bus.write ? bus.writedata : 32'h0});
        if (bus.write) begin
          if (bus.address == REG_X) s_x <= bus.writedata;
          if (bus.address == REG_A) s_a <= bus.writedata;
          if (bus.address == REG_CTRL && bus.writedata == CTRL_START) s_polls <= 0;
        end else if (bus.address == REG_STATUS) begin
          s_polls      <= s_polls + 1;
          bus.readdata <= {31'h0, (s_polls + 1 >= done_after)};
        end else if (bus.address == REG_RESULT) begin
          bus.readdata <= pow32(s_x, s_a);
        end else begin
          bus.readdata <= 32'h0;
        end
      end
    end
  end

  // Held-transfer and read/write exclusivity monitor.
  int          hold_viol = 0;
  logic        hold_pend = 1'b0;
  logic [37:0] hold_saved = '0;
  always @(negedge clk) begin
    logic [37:0] cur;
    cur = {bus.read, bus.write, bus.address, bus.writedata};
    if (hold_pend && cur != hold_saved) hold_viol++;
    if (bus.read && bus.write) hold_viol++;
    hold_pend  = bus.waitrequest;
    hold_saved = cur;
  end

  // ---- never-done slave for dut_to ----
  int to_stat = 0, to_res = 0;
  assign bus2.waitrequest = 1'b0;
  assign bus2.readdata    = 32'h0;
  always @(posedge clk) begin
    if (bus2.read && bus2.address == REG_STATUS) to_stat <= to_stat + 1;
    if (bus2.read && bus2.address == REG_RESULT) to_res <= to_res + 1;
  end

  task automatic check_seq(input int base, input logic [31:0] x, input logic [31:0] a,
                           input int p);
    logic [36:0] q[$];
    q.push_back({1'b1, REG_X, x});
    q.push_back({1'b1, REG_A, a});
    q.push_back({1'b1, REG_CTRL, CTRL_START});
    for (int i = 0; i < p; i++) q.push_back({1'b0, REG_STATUS, 32'h0});
    q.push_back({1'b0, REG_RESULT, 32'h0});
    check("bus_len", txn_log.size() - base, q.size());
    for (int i = 0; i < q.size(); i++)
      if (base + i < txn_log.size()) check("bus_txn", txn_log[base + i], q[i]);
  endtask

  task automatic run_cmd(input logic [31:0] x, input logic [31:0] a, input int p,
                         input int hold, output int lat, output logic [31:0] res,
                         output logic to);
    done_after = p;
    @(negedge clk);
    cmd_x = x; cmd_a = a; cmd_valid = 1'b1;
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    check("cmd_ready_busy", cmd_ready, 0);
    lat = 0;
    while (!rsp_valid && lat < 4000) begin
      @(posedge clk); #1 lat++;
    end
    if (!rsp_valid) check("rsp_wait_bound", 0, 1);
    res = rsp_result;
    to  = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_result", rsp_result, res);
      check("hold_timeout", rsp_timeout, to);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    check("cmd_ready_after_hs", cmd_ready, 1);
    check("rsp_valid_after_hs", rsp_valid, 0);
  endtask

  initial begin
    int          lat, base, s0, p, n;
    logic [31:0] res, x, a;
    logic        to;

    // Reset with the clock stopped.
    reset = 1'b1;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_m_read", bus.read, 0);
    check("rst_m_write", bus.write, 0);
    check("rst_m_address", bus.address, 0);
    check("rst_m_writedata", bus.writedata, 0);
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // 3^4, done on first poll.
    base = txn_log.size();
    run_cmd(32'd3, 32'd4, 1, 0, lat, res, to);
    check("t1_result", res, 81);
    check("t1_timeout", to, 0);
    check("t1_latency", lat, 8);
    check_seq(base, 32'd3, 32'd4, 1);

    // Two stall cycles on the A write.
    base = txn_log.size();
    stall_addr  = REG_A;
    stall_total = dir_used + 2;
    run_cmd(32'd3, 32'd4, 1, 0, lat, res, to);
    check("t2_result", res, 81);
    check("t2_latency", lat, 10);
    check("t2_hold_stable", hold_viol, 0);
    check_seq(base, 32'd3, 32'd4, 1);

    // 2^10, done on fifth poll.
    base = txn_log.size();
    run_cmd(32'd2, 32'd10, 5, 0, lat, res, to);
    check("t3_result", res, 1024);
    check("t3_latency", lat, 16);
    check_seq(base, 32'd2, 32'd10, 5);

    // Timeout on the MAX_POLLS=4, READ_LATENCY=2 instance.
    @(negedge clk) t_cmd_valid = 1'b1;
    @(posedge clk); #1 t_cmd_valid = 1'b0;
    n = 0;
    while (!t_rsp_valid && n < 4000) begin
      @(posedge clk); #1 n++;
    end
    check("to_latency", n, 16);
    check("to_timeout", t_rsp_timeout, 1);
    check("to_result", t_rsp_result, 0);
    check("to_status_reads", to_stat, 4);
    check("to_result_reads", to_res, 0);
    t_rsp_ready = 1'b1;
    @(posedge clk); #1 t_rsp_ready = 1'b0;
    check("to_cmd_ready_after_hs", t_cmd_ready, 1);

    // Response held under backpressure.
    run_cmd(32'd7, 32'd3, 2, 3, lat, res, to);
    check("t5_result", res, 343);
    check("t5_latency", lat, 10);

    // Async reset during the start write.
    done_after = 1;
    @(negedge clk);
    cmd_x = 32'd9; cmd_a = 32'd9; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n = 0;
    while (!(bus.write && bus.address == REG_CTRL) && n < 100) begin
      @(posedge clk); #1 n++;
    end
    check("t6_reached_wr_go", bus.write && bus.address == REG_CTRL, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_m_write", bus.write, 0);
    check("t6_rst_m_address", bus.address, 0);
    check("t6_rst_cmd_ready", cmd_ready, 1);
    check("t6_rst_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    base = txn_log.size();
    run_cmd(32'd5, 32'd2, 1, 0, lat, res, to);
    check("t6_result", res, 25);
    check("t6_latency", lat, 8);
    check_seq(base, 32'd5, 32'd2, 1);

    // Random operands, poll counts and waitrequest stalls.
    rand_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      x = $urandom;
      a = $urandom_range(0, 40);
      p = $urandom_range(1, 6);
      base = txn_log.size();
      s0 = stalls;
      run_cmd(x, a, p, 0, lat, res, to);
      check("rnd_result", res, pow32(x, a));
      check("rnd_timeout", to, 0);
      check("rnd_latency", lat, 3 + (p + 1) * 2 + 1 + (stalls - s0));
      check_seq(base, x, a, p);
    end
    rand_en = 1'b0;
    check("rnd_hold_stable", hold_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exp_master.md
# exp_master

Avalon-MM master that drives the memory-mapped exponent accelerator slave on behalf of a local requester. It accepts an (x, a) command on a valid/ready port, writes the operands and a start command into the accelerator's registers, polls its status register until done, reads back p = x^a, and returns it on a valid/ready response port. It sits between host-side control logic and the accelerator slave, forming the initiator end of the same register interface.

## Interface
- READ_LATENCY, 1: cycles from an accepted read to readdata valid; minimum 1.
- MAX_POLLS, 1024: status reads before giving up; minimum 1.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_x  in  32  base operand.
- cmd_a  in  32  exponent operand.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_result  out  32  p, low 32 bits; 0 on timeout.
- rsp_timeout  out  1  1 when polling exhausted MAX_POLLS.
- m_address  out  4  word address to slave.
- m_read  out  1  read strobe.
- m_write  out  1  write strobe.
- m_writedata  out  32  write data.
- m_readdata  in  32  read data.
- m_waitrequest  in  1  slave stall; the current transfer is held.

## Operation
- Register map (word addresses): 0 X, 1 A, 2 CTRL (write 1 = start), 3 STATUS (bit 0 = done), 4 RESULT.
- States: IDLE, WR_X, WR_A, WR_GO, RD_STAT, WAIT_STAT, RD_RES, WAIT_RES, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch x and a, clear the poll counter, and go to WR_X.
- WR_X/WR_A/WR_GO: drive m_write=1 with (0,x), (1,a), (2,1) respectively. Advance on a cycle with m_waitrequest=0.
- RD_STAT: drive m_read=1 at address 3. Once accepted, go to WAIT_STAT and increment the poll counter.
- WAIT_STAT: hold for READ_LATENCY cycles, then sample m_readdata[0].
  - If bit 0 is 1, go to RD_RES.
  - Else, if the poll count equals MAX_POLLS, go to RESP with rsp_timeout=1 and rsp_result=0; address 4 is never read.
  - Else, go back to RD_STAT.
- RD_RES/WAIT_RES: read address 4 with the same timing, latch it into rsp_result, then go to RESP.
- RESP: rsp_valid=1. rsp_result and rsp_timeout stay stable until rsp_valid && rsp_ready, then go to IDLE.
- While m_waitrequest=1, m_address, m_writedata, m_read and m_write are held unchanged.
- At most one of m_read/m_write is high; both are low outside the RD_*/WR_* states.
- Arithmetic: 32-bit unsigned only. The poll counter is $clog2(MAX_POLLS+1) bits wide and never wraps.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_timeout=0, m_read=0, m_write=0, m_address=0, m_writedata=0; state IDLE.
- Reset asserted mid-operation: all outputs take their reset values immediately, without waiting for a clock edge. The in-flight bus transfer is abandoned.
- Latency, no stalls, done on poll P: rsp_valid rises 3 + (P+1)(1+READ_LATENCY) + 1 cycles after the cmd acceptance edge. That is 8 cycles for P=1 with READ_LATENCY=1.
- Each waitrequest cycle adds exactly one cycle.
- Acceptance is one transaction at a time: cmd_ready=0 from the acceptance edge until the cycle after the response handshake. A command cannot be accepted in the same cycle as the response handshake.

## Structure
- Shared package exp_master_pkg holds:
  - the register offsets REG_X, REG_A, REG_CTRL, REG_STATUS, REG_RESULT;
  - CTRL_START = 32'h1 and STATUS_DONE_BIT = 0;
  - the state enum type.
- The accelerator slave imports the same package.
- One sub-module, avmm_txn, issues a single read or write, honours waitrequest and READ_LATENCY, and pulses done with the captured readdata.

## Test plan
- Reset: with clock stopped, assert reset -> all outputs at their reset values, cmd_ready=1.
- x=3, a=4, slave reports done on the first poll, no stalls -> bus sequence W(0,3), W(1,4), W(2,1), R(3), R(4). rsp_result=81, rsp_timeout=0, rsp_valid 8 cycles after acceptance.
- m_waitrequest held high for 2 cycles during WR_A -> address 1 and data 4 stay stable throughout; the response is 2 cycles later.
- x=2, a=10, done on the 5th poll -> exactly 5 reads of address 3, then one read of address 4; rsp_result=1024.
- MAX_POLLS=4, done never set -> 4 status reads, no read of address 4, rsp_timeout=1, rsp_result=0.
- rsp_ready held low for 3 cycles, then async reset pulsed during a later WR_GO:
  - while rsp_ready is low, the response stays stable and cmd_ready stays 0;
  - on reset, m_write drops immediately, and the next command x=5, a=2 returns 25.
